// File: rtl/jts16_obj_pkg.sv
// Shared constants and FSM state type for the object line buffer.
package jts16_obj_pkg;

  localparam int          OBJ_BUF_AW = 9;
  localparam int          OBJ_BUF_DW = 12;
  localparam logic [11:0] OBJ_TRANSP = 12'hFFF;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } obj_state_e;

endpackage

// File: rtl/jts16_obj_bank.sv
// One line bank: simple dual-port RAM, one write port, one registered read port.
module jts16_obj_bank #(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];

  // Storage write and registered read; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem_r[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/jts16_obj_linebuf.sv
// Double-buffered object line buffer with read-then-erase and post-reset clear sweep.
// Optional screen flip on the read side is enabled by defining JTS16_OBJ_FLIP_EN.
module jts16_obj_linebuf
  import jts16_obj_pkg::*;
#(
  parameter int AW = OBJ_BUF_AW,
  parameter int DW = OBJ_BUF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic [DW-1:0] bf_data,
  input  logic          bf_we,
  input  logic [AW-1:0] bf_addr,
  input  logic [AW-1:0] hdump,
`ifdef JTS16_OBJ_FLIP_EN
  input  logic          flip,
`endif
  output logic [DW-1:0] pxl,
  output logic          line,
  output logic          init
);

  localparam logic [DW-1:0] TRANSP = DW'(OBJ_TRANSP);

  obj_state_e    state_r, state_nx_s;
  logic [AW-1:0] clr_cnt_r, rd_addr_s, rd_addr_r;
  logic [DW-1:0] pxl_r;
  logic          hs_l_r, line_r, init_r, rd_pend_r, rd_bank_r;
  logic          hs_rise_s, rd_en_s, last_s;

  logic          bk_we_s [2];
  logic [AW-1:0] bk_wa_s [2];
  logic [DW-1:0] bk_wd_s [2];
  logic [DW-1:0] bk_q_s  [2];

  assign hs_rise_s = hs & ~hs_l_r;
  assign rd_en_s   = (state_r == RUN) & pxl_cen;
  assign last_s    = (clr_cnt_r == {AW{1'b1}});
  assign pxl       = pxl_r;
  assign line      = line_r;
  assign init      = init_r;

`ifdef JTS16_OBJ_FLIP_EN
  assign rd_addr_s = flip ? ~hdump : hdump;
`else
  assign rd_addr_s = hdump;
`endif

  // Next-state logic: sweep once, then run forever
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      CLEAR: begin
        if (last_s) state_nx_s = RUN;
        else        state_nx_s = CLEAR;
      end
      RUN:     state_nx_s = RUN;
      default: state_nx_s = CLEAR;
    endcase
  end

  // FSM state, clear sweep counter and init flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLEAR;
      init_r    <= 1'b1;
      clr_cnt_r <= {AW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      init_r  <= (state_nx_s == CLEAR);
      if (state_r == CLEAR) clr_cnt_r <= clr_cnt_r + AW'(1);
    end
  end

  // Line swap, read request latching and pixel output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l_r    <= 1'b0;
      line_r    <= 1'b0;
      rd_pend_r <= 1'b0;
      rd_bank_r <= 1'b0;
      rd_addr_r <= {AW{1'b0}};
      pxl_r     <= TRANSP;
    end else begin
      hs_l_r    <= hs;
      if (hs_rise_s) line_r <= ~line_r;
      rd_pend_r <= rd_en_s;
      if (rd_en_s) begin
        rd_bank_r <= ~line_r;
        rd_addr_r <= rd_addr_s;
      end
      if (rd_pend_r) pxl_r <= rd_bank_r ? bk_q_s[1] : bk_q_s[0];
    end
  end

  // Bank write port mux. A draw write wins over an erase when a swap makes both
  // target the same bank; new line data must never be wiped.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bk_we_s[b] = 1'b0;
      bk_wa_s[b] = bf_addr;
      bk_wd_s[b] = bf_data;
      if (state_r == CLEAR) begin
        bk_we_s[b] = 1'b1;
        bk_wa_s[b] = clr_cnt_r;
        bk_wd_s[b] = TRANSP;
      end else if (bf_we && (line_r == 1'(b))) begin
        bk_we_s[b] = 1'b1;
      end else if (rd_pend_r && (rd_bank_r == 1'(b))) begin
        bk_we_s[b] = 1'b1;
        bk_wa_s[b] = rd_addr_r;
        bk_wd_s[b] = TRANSP;
      end else begin
        bk_we_s[b] = 1'b0;
      end
    end
  end

  jts16_obj_bank #(.AW(AW), .DW(DW)) u_bank0 (
    .clk     (clk),
    .we      (bk_we_s[0]),
    .wr_addr (bk_wa_s[0]),
    .wr_data (bk_wd_s[0]),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (bk_q_s[0])
  );

  jts16_obj_bank #(.AW(AW), .DW(DW)) u_bank1 (
    .clk     (clk),
    .we      (bk_we_s[1]),
    .wr_addr (bk_wa_s[1]),
    .wr_data (bk_wd_s[1]),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (bk_q_s[1])
  );

endmodule

// File: doc/jts16_obj_linebuf.md
JTS16_OBJ_LINEBUF -- requirements
Module: jts16_obj_linebuf

Interface
REQ-001 SHALL have parameters: AW, default 9, buffer address width; DW, default 12, pixel word width {prio[1:0], pal[5:0], pxl[3:0]}.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port pxl_cen, input, 1, pixel clock enable for the read side.
REQ-005 SHALL have port hs, input, 1, horizontal sync; the line swaps on its rising edge.
REQ-006 SHALL have port bf_data, input, DW, pixel word from the object draw engine.
REQ-007 SHALL have port bf_we, input, 1, write strobe from the object draw engine.
REQ-008 SHALL have port bf_addr, input, AW, write x position from the object draw engine.
REQ-009 SHALL have port hdump, input, AW, current video read x position.
REQ-010 SHALL have port flip, input, 1, screen flip; it is present only when JTS16_OBJ_FLIP_EN is defined.
REQ-011 SHALL have port pxl, output, DW, registered object pixel for the mixer.
REQ-012 SHALL have port line, output, 1, index of the bank currently being written.
REQ-013 SHALL have port init, output, 1, high while the post-reset clear sweep runs.

Function
REQ-014 SHALL hold two banks of 2^AW x DW; bank[line] is the write bank and bank[~line] is the read bank.
REQ-015 SHALL detect the hs rising edge synchronously (hs registered into hs_l) and toggle line on the clk edge after the hs rise.
REQ-016 SHALL write bf_data into bank[line] at bf_addr on every clk with bf_we=1 while in RUN; writes overwrite unconditionally and perform no transparency check.
REQ-017 SHALL, on a clk with pxl_cen=1 in RUN, read bank[~line] at address rd_addr, where rd_addr = hdump.
REQ-018 SHALL update pxl exactly one clk after the pxl_cen cycle with the read word, and SHALL hold pxl at all other times.
REQ-019 SHALL, on the same edge that pxl updates, write 12'hFFF (transparent) into the read bank at the latched rd_addr (read-then-erase).
REQ-020 SHALL sample bank selection for a draw write or an erase in the cycle the request is issued; if a swap coincides, the access goes to the pre-swap bank.
REQ-021 SHALL let address arithmetic wrap modulo 2^AW; bf_addr=511 followed by 0 is legal.
REQ-022 SHALL implement an FSM with states CLEAR and RUN; CLEAR sweeps addresses 0..2^AW-1 writing 12'hFFF to both banks, one address per clk.
REQ-023 SHALL, in CLEAR, keep init=1, hold pxl=12'hFFF, and ignore bf_we and pxl_cen; after the last address it SHALL go to RUN and drop init on the same edge.

Reset
REQ-024 SHALL, during rst, force line=0, pxl=12'hFFF, init=1, FSM=CLEAR, sweep counter=0 and hs_l=0.
REQ-025 SHALL, when rst is asserted mid-operation, abort any pending erase and restart the full CLEAR sweep after release.
REQ-026 SHALL not reset RAM contents directly; the CLEAR sweep provides initialisation.

Configuration
REQ-027 SHALL, when JTS16_OBJ_FLIP_EN is defined, use rd_addr = flip ? ~hdump : hdump, and SHALL latch that same rd_addr for the erase.
REQ-028 SHALL, when JTS16_OBJ_FLIP_EN is not defined, omit the flip port and use rd_addr = hdump.

Structure
REQ-029 SHALL take from shared package jts16_obj_pkg: OBJ_BUF_AW=9, OBJ_BUF_DW=12, OBJ_TRANSP=12'hFFF, and the FSM state enum {CLEAR, RUN}.
REQ-030 SHALL instantiate sub-module jts16_obj_bank twice: a simple dual-port RAM with one write port and one registered read port.
REQ-031 SHALL keep the read/erase address mux and the bank select logic in the top module.

Verification
REQ-032 SHALL cover post-reset clear: release rst -> init=1 for exactly 512 clk, then 0; all reads return 12'hFFF.
REQ-033 SHALL cover draw-then-display: line=0, write 12'h5A3 at bf_addr=37, raise hs -> line=1; pxl_cen with hdump=37 -> pxl=12'h5A3 one clk later.
REQ-034 SHALL cover erase after read: repeat the read of address 37 on the following line with that bank read again -> pxl=12'hFFF.
REQ-035 SHALL cover a swap collision: bf_we at bf_addr=100 on the same clk as the toggle edge -> data lands in the old write bank and appears on the next displayed line.
REQ-036 SHALL cover wrap: writes at 510, 511, 0 -> all three read back correctly; no write spills into the read bank.
REQ-037 SHALL cover flip (macro defined): flip=1, pixel written at 5, hdump=506 -> pxl equals the written word, and address 5 is erased.
